// File: rtl/gpio_mailbox_ctrl.sv
// Turns PS EMIO GPIO request toggles into single valid/ready register-bus accesses.
// Results and a registered status word are returned on gpio_i, and the toggle is mirrored as ack.
module gpio_mailbox_ctrl #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STATUS_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         gpio_o,
  output logic [63:0]         gpio_i,
  output logic                reg_valid,
  output logic                reg_write,
  output logic [7:0]          reg_addr,
  output logic [31:0]         reg_wdata,
  input  logic                reg_ready,
  input  logic [31:0]         reg_rdata,
  input  logic [STATUS_W-1:0] status_in,
  output logic [2:0]          o_dbg_state
);

  // Bus handshake: an access completes on the cycle where reg_valid && reg_ready.
  // reg_write/reg_addr/reg_wdata stay constant while reg_valid is high; reg_valid
  // may be withdrawn without a handshake when the access times out.

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [41:0]      r_snap;
  logic [SET_W-1:0] r_settle_cnt;
  logic [TMO_W-1:0] r_timeout_cnt;
  logic             r_ack;
  logic             r_err;
  logic [31:0]      r_rdata;
  logic [15:0]      r_status;
  logic [15:0]      w_status16;

  logic w_req_pending;
  logic w_gpio_changed;
  logic w_snap_load;
  logic w_settle_inc;
  logic w_launch;
  logic w_accept;
  logic w_timeout;
  logic w_busy;
  logic w_unused;

  assign w_req_pending  = (gpio_o[41] != r_ack);
  assign w_gpio_changed = (gpio_o[41:0] != r_snap);
  assign w_unused       = ^gpio_o[63:42];

  always_comb begin
    w_state_nxt  = r_state;
    w_snap_load  = 1'b0;
    w_settle_inc = 1'b0;
    w_launch     = 1'b0;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_INIT: w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (w_req_pending) begin
          w_snap_load = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // A double toggle cancels the command before any bus activity.
        if (!w_req_pending) begin
          w_state_nxt = ST_IDLE;
        end else if (w_gpio_changed) begin
          w_snap_load = 1'b1;
        end else if (r_settle_cnt == SET_MAX) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_settle_inc = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (reg_valid && reg_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_timeout_cnt == TMO_MAX) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_INIT;
      r_snap        <= '0;
      r_settle_cnt  <= '0;
      r_timeout_cnt <= '0;
      r_ack         <= 1'b0;
      r_err         <= 1'b0;
      r_rdata       <= '0;
      r_status      <= '0;
      reg_valid     <= 1'b0;
      reg_write     <= 1'b0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= w_status16;
      // A req level already present out of reset is adopted as the ack level.
      if (r_state == ST_INIT) r_ack <= gpio_o[41];
      if (r_state == ST_DONE) r_ack <= r_snap[41];

      if (w_snap_load) begin
        r_snap       <= gpio_o[41:0];
        r_settle_cnt <= '0;
      end else if (w_settle_inc && (r_settle_cnt != SET_MAX)) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end

      if (w_launch) begin
        reg_valid     <= 1'b1;
        reg_write     <= r_snap[40];
        reg_addr      <= r_snap[39:32];
        reg_wdata     <= r_snap[31:0];
        r_timeout_cnt <= '0;
      end else if ((r_state == ST_ISSUE) && (r_timeout_cnt != TMO_MAX)) begin
        r_timeout_cnt <= r_timeout_cnt + 1'b1;
      end

      if (w_accept) begin
        reg_valid <= 1'b0;
        r_err     <= 1'b0;
        if (!reg_write) r_rdata <= reg_rdata;
      end else if (w_timeout) begin
        reg_valid <= 1'b0;
        r_err     <= 1'b1;
        r_rdata   <= 32'hDEAD_BEEF;
      end
    end
  end

  generate
    if (STATUS_W >= 16) begin : g_status_trunc
      assign w_status16 = status_in[15:0];
    end else begin : g_status_zext
      assign w_status16 = {{(16 - STATUS_W){1'b0}}, status_in};
    end
  endgenerate

  assign w_busy      = (r_state == ST_SETTLE) || (r_state == ST_ISSUE) || (r_state == ST_DONE);
  assign gpio_i      = {r_status, 4'b0000, w_busy, r_err, r_ack, 9'b0, r_rdata};
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gpio_mailbox_ctrl.sv
// Directed and randomized stimulus for gpio_mailbox_ctrl, checked against a transaction-level
// model: expected bus accesses in a queue, plus the rdata/ack values the PS should observe.
module tb_gpio_mailbox_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] gpio_o;
  logic [63:0] gpio_i;
  logic        reg_valid;
  logic        reg_write;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ready;
  logic [31:0] reg_rdata;
  logic [15:0] status_in;
  logic [2:0]  dbg_state;

  gpio_mailbox_ctrl #(
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(1024),
    .STATUS_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .gpio_o(gpio_o),
    .gpio_i(gpio_i),
    .reg_valid(reg_valid),
    .reg_write(reg_write),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_ready(reg_ready),
    .reg_rdata(reg_rdata),
    .status_in(status_in),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model state ----------------
  int          checks = 0;
  int          errors = 0;
  int          n_acc = 0;       // handshakes seen on the bus
  int          model_acc = 0;   // handshakes the model expects
  logic        model_ack;
  logic        model_req;
  logic [31:0] model_rdata;
  logic [40:0] exp_q[$];        // {write, addr, wdata}

  always @(posedge clk) begin
    if (!reset && reg_valid && reg_ready) n_acc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    model_req = ~model_ack;
    gpio_o    = {22'h0, model_req, wr, addr, wd};
  endtask

  task automatic send(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    drive_cmd(wr, addr, wd);
    exp_q.push_back({wr, addr, wd});
  endtask

  task automatic wait_valid(input int exp_lat);
    int lat;
    lat = 0;
    while (!reg_valid && lat < 40) begin
      step(1);
      lat++;
    end
    check("valid_latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic serve(input int delay, input logic [31:0] rd);
    logic [40:0] exp;
    logic [15:0] s;
    exp = exp_q.pop_front();
    check("access", {23'h0, reg_write, reg_addr, reg_wdata}, {23'h0, exp});
    check("busy_issue", 64'(gpio_i[43]), 64'd1);
    reg_rdata = rd;
    for (int i = 0; i < delay; i++) begin
      s = 16'($urandom);
      status_in = s;
      step(1);
      check("status_busy", 64'(gpio_i[63:48]), 64'(s));
      check("hold", {22'h0, reg_valid, reg_write, reg_addr, reg_wdata}, {22'h0, 1'b1, exp});
    end
    reg_ready = 1'b1;
    step(1);
    reg_ready = 1'b0;
    reg_rdata = $urandom;
    model_acc++;
    if (!exp[40]) model_rdata = rd;
    check("valid_drop", 64'(reg_valid), 64'd0);
    check("rdata_before_ack", 64'(gpio_i[31:0]), 64'(model_rdata));
    check("err_ok", 64'(gpio_i[42]), 64'd0);
    check("ack_not_yet", 64'(gpio_i[41]), 64'(model_ack));
    step(1);
    model_ack = model_req;
    check("ack_toggle", 64'(gpio_i[41]), 64'(model_ack));
    check("busy_end", 64'(gpio_i[43]), 64'd0);
    check("rdata_at_ack", 64'(gpio_i[31:0]), 64'(model_rdata));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [40:0] dropped;
    logic [31:0] w1;
    logic [31:0] w2;
    int          cnt;
    int          acc_before;

    reset     = 1'b1;
    gpio_o    = '0;
    reg_ready = 1'b0;
    reg_rdata = '0;
    status_in = '0;
    model_ack = 1'b0;
    model_req = 1'b0;
    model_rdata = '0;
    step(3);
    check("rst_gpio_i", gpio_i, 64'h0);
    check("rst_bus", {23'h0, reg_valid, reg_write, reg_addr, reg_wdata}, 64'h0);
    reset = 1'b0;
    step(2);
    check("idle_busy", 64'(gpio_i[43]), 64'd0);

    // T1 write
    send(1'b1, 8'h12, 32'hCAFE_0001);
    wait_valid(5);
    serve(3, 32'h1357_9BDF);

    // T2 read
    send(1'b0, 8'h34, $urandom);
    wait_valid(5);
    serve(1, 32'h0000_00A5);

    // T3 glitch at settle_cnt==2: one access with the final wdata
    acc_before = n_acc;
    w1 = $urandom;
    w2 = ~w1;
    drive_cmd(1'b1, 8'h56, w1);
    step(3);
    gpio_o[31:0] = w2;
    exp_q.push_back({1'b1, 8'h56, w2});
    wait_valid(5);
    serve(0, $urandom);
    check("glitch_one_access", 64'(n_acc - acc_before), 64'd1);

    // T4 timeout
    send(1'b0, 8'h78, $urandom);
    wait_valid(5);
    dropped = exp_q.pop_front();
    check("tmo_access", {23'h0, reg_write, reg_addr, reg_wdata}, {23'h0, dropped});
    cnt = 0;
    while (reg_valid && cnt < 1200) begin
      step(1);
      cnt++;
    end
    model_rdata = 32'hDEAD_BEEF;
    check("tmo_cycles", 64'(cnt), 64'd1024);
    check("tmo_rdata", 64'(gpio_i[31:0]), 64'(model_rdata));
    check("tmo_err", 64'(gpio_i[42]), 64'd1);
    check("tmo_ack_not_yet", 64'(gpio_i[41]), 64'(model_ack));
    step(1);
    model_ack = model_req;
    check("tmo_ack", 64'(gpio_i[41]), 64'(model_ack));
    check("tmo_busy_end", 64'(gpio_i[43]), 64'd0);

    // Double toggle before ack: command is lost
    acc_before = n_acc;
    drive_cmd(1'b1, 8'hAB, $urandom);
    step(2);
    gpio_o[41] = model_ack;
    step(8);
    check("revert_no_valid", 64'(reg_valid), 64'd0);
    check("revert_ack", 64'(gpio_i[41]), 64'(model_ack));
    check("revert_no_access", 64'(n_acc - acc_before), 64'd0);

    // Randomized transactions
    for (int k = 0; k < 10; k++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom), $urandom);
      wait_valid(5);
      serve($urandom_range(0, 4), $urandom);
    end

    // T6 status while idle
    status_in = 16'h00F3;
    step(1);
    check("status_idle", 64'(gpio_i[63:48]), 64'h00F3);

    // T5 reset during ISSUE: valid drops, no ack, INIT resyncs ack to req
    acc_before = n_acc;
    send(1'b1, 8'hC0, $urandom);
    wait_valid(5);
    dropped = exp_q.pop_back();
    reset = 1'b1;
    step(1);
    check("rst_issue_valid", 64'(reg_valid), 64'd0);
    check("rst_issue_ack", 64'(gpio_i[41]), 64'd0);
    reset = 1'b0;
    step(2);
    model_ack = model_req;
    model_rdata = '0;
    check("rst_issue_resync", 64'(gpio_i[41]), 64'(model_ack));
    check("rst_issue_rdata", 64'(gpio_i[31:0]), 64'(model_rdata));
    step(8);
    check("rst_issue_idle", 64'(reg_valid), 64'd0);
    check("rst_issue_no_access", 64'(n_acc - acc_before), 64'd0);

    // T5 reset with req=1 already high
    reset  = 1'b1;
    gpio_o = {22'h0, 1'b1, 1'b1, 8'h9A, 32'h0000_0001};
    step(2);
    reset = 1'b0;
    step(10);
    model_ack = 1'b1;
    check("rst_req_no_valid", 64'(reg_valid), 64'd0);
    check("rst_req_ack", 64'(gpio_i[41]), 64'd1);
    check("rst_req_no_access", 64'(n_acc - acc_before), 64'd0);

    // Still operational afterwards
    send(1'b0, 8'hEE, $urandom);
    wait_valid(5);
    serve(2, $urandom);

    step(2);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("access_count", 64'(n_acc), 64'(model_acc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
